// File: rtl/counter_run_controller.sv
// Run/stop, direction and clear sequencer for the hex counter display datapath.
// Raw push-buttons are synchronised and debounced, then they gate a prescaled 24-bit up/down count.
module counter_run_controller #(
  parameter int unsigned TICK_DIV        = 5000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  key_n,
  output logic [23:0] count,
  output logic        running,
  output logic        count_up,
  output logic        tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  run_state_t      state;
  logic [PW-1:0]   presc;
  logic [2:0]      sync_a;
  logic [2:0]      sync_b;
  logic [1:0]      sync_fill;
  logic [2:0]      key_deb;
  logic [2:0]      key_armed;
  logic [2:0]      key_press;
  logic [DW-1:0]   db_cnt [3];
  logic            step;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a    <= '1;
      sync_b    <= '1;
      sync_fill <= '0;
    end else begin
      sync_a    <= key_n;
      sync_b    <= sync_a;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // A key only arms once the flushed synchroniser shows it released, so a
  // button held through reset cannot produce a press until it is let go.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_deb   <= '1;
      key_armed <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync_b[i] == key_deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_deb[i] <= sync_b[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
        if (sync_fill[1] && key_deb[i] && sync_b[i]) begin
          key_armed[i] <= 1'b1;
        end
      end
    end
  end

  // Press is decoded on the edge that flips the debounced level so the
  // command lands on that same edge.
  always_comb begin
    key_press = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      key_press[i] = key_armed[i] & key_deb[i] & ~sync_b[i] & (db_cnt[i] == DB_LAST);
    end
  end

  assign step    = (state == RUNNING) && (presc == PRESC_LAST);
  assign running = (state == RUNNING);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= STOPPED;
      presc    <= '0;
      count    <= '0;
      count_up <= 1'b1;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (key_press[2]) begin
        count <= '0;
        presc <= '0;
      end else if (step) begin
        presc <= '0;
        count <= count_up ? count + 24'd1 : count - 24'd1;
        tick  <= 1'b1;
      end else if (state == RUNNING) begin
        presc <= presc + 1'b1;
      end
      if (key_press[1]) begin
        count_up <= ~count_up;
      end
      if (key_press[0]) begin
        state <= (state == RUNNING) ? STOPPED : RUNNING;
      end
    end
  end

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller with TICK_DIV=3, DEBOUNCE_CYCLES=4.
// A clean key fall set just after edge n is acted on at edge n+6.
module tb_counter_run_controller;

  logic        clock;
  logic        reset_n;
  logic [2:0]  key_n;
  logic [23:0] count;
  logic        running;
  logic        count_up;
  logic        tick;

  int errors = 0;
  int checks = 0;

  counter_run_controller #(
    .TICK_DIV        (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .key_n    (key_n),
    .count    (count),
    .running  (running),
    .count_up (count_up),
    .tick     (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  key;
    int          n;
    logic [23:0] cnt;
    logic        run;
    logic        up;
    logic        tk;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [2:0] k, input int n, input logic [23:0] c,
                     input logic r, input logic u, input logic t);
    vec_t v;
    v.key = k; v.n = n; v.cnt = c; v.run = r; v.up = u; v.tk = t;
    vq.push_back(v);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [26:0] pk(input logic [23:0] c, input logic r,
                                     input logic u, input logic t);
    return {c, r, u, t};
  endfunction

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got count=%h run=%b up=%b tick=%b, expected count=%h run=%b up=%b tick=%b",
               name, act[26:3], act[2], act[1], act[0], exp[26:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // e1..: start press, direction press one cycle later, run/wrap down, release.
    add(3'b110, 1,  24'h000000, 0, 1, 0);
    add(3'b100, 4,  24'h000000, 0, 1, 0);
    add(3'b100, 1,  24'h000000, 1, 1, 0);
    add(3'b100, 1,  24'h000000, 1, 0, 0);
    add(3'b100, 1,  24'h000000, 1, 0, 0);
    add(3'b100, 1,  24'hFFFFFF, 1, 0, 1);
    add(3'b100, 2,  24'hFFFFFF, 1, 0, 0);
    add(3'b100, 1,  24'hFFFFFE, 1, 0, 1);
    add(3'b111, 3,  24'hFFFFFD, 1, 0, 1);
    add(3'b111, 3,  24'hFFFFFC, 1, 0, 1);
    // Direction press coincident with a step: old direction used for that step.
    add(3'b101, 3,  24'hFFFFFB, 1, 0, 1);
    add(3'b101, 2,  24'hFFFFFB, 1, 0, 0);
    add(3'b101, 1,  24'hFFFFFA, 1, 1, 1);
    add(3'b111, 3,  24'hFFFFFB, 1, 1, 1);
    add(3'b111, 12, 24'hFFFFFF, 1, 1, 1);
    add(3'b111, 3,  24'h000000, 1, 1, 1);
    add(3'b111, 12, 24'h000004, 1, 1, 1);
    // Clear lands on the edge that would step 5 -> 6.
    add(3'b011, 3,  24'h000005, 1, 1, 1);
    add(3'b011, 1,  24'h000005, 1, 1, 0);
    add(3'b010, 1,  24'h000005, 1, 1, 0);
    add(3'b010, 1,  24'h000000, 1, 1, 0);
    add(3'b110, 2,  24'h000000, 1, 1, 0);
    add(3'b110, 1,  24'h000001, 1, 1, 1);
    // Stop with prescaler at 1, idle, restart: tick two edges after restart.
    add(3'b110, 1,  24'h000001, 0, 1, 0);
    add(3'b111, 10, 24'h000001, 0, 1, 0);
    add(3'b110, 5,  24'h000001, 0, 1, 0);
    add(3'b110, 1,  24'h000001, 1, 1, 0);
    add(3'b110, 1,  24'h000001, 1, 1, 0);
    add(3'b110, 1,  24'h000002, 1, 1, 1);
    add(3'b111, 3,  24'h000003, 1, 1, 1);
    add(3'b111, 6,  24'h000005, 1, 1, 1);

    reset_n = 1'b0;
    key_n   = 3'($urandom);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("reset_hold", {count, running, count_up, tick}, pk(24'h0, 0, 1, 0));
      key_n = 3'($urandom);
    end
    key_n   = 3'b111;
    reset_n = 1'b1;
    cyc(50);
    check("reset_idle", {count, running, count_up, tick}, pk(24'h0, 0, 1, 0));

    for (int i = 0; i < vq.size(); i++) begin
      key_n = vq[i].key;
      cyc(vq[i].n);
      check($sformatf("vec%0d", i), {count, running, count_up, tick},
            pk(vq[i].cnt, vq[i].run, vq[i].up, vq[i].tk));
    end

    // Bounce on start/stop: 2-cycle runs never reach the debounce length.
    for (int ph = 0; ph < 10; ph++) begin
      key_n = (ph % 2 == 0) ? 3'b110 : 3'b111;
      for (int j = 0; j < 2; j++) begin
        cyc(1);
        check("bounce", {26'b0, running}, 27'd1);
      end
    end
    key_n = 3'b110;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      check($sformatf("bounce_hold%0d", k), {26'b0, running}, 27'(k < 6));
    end
    key_n = 3'b111;
    cyc(8);
    check("bounce_release", {26'b0, running}, 27'd0);

    // Reset while a clear press is debouncing; key stays held through reset.
    key_n = 3'b011;
    cyc(3);
    reset_n = 1'b0;
    #1;
    check("async_reset", {count, running, count_up, tick}, pk(24'h0, 0, 1, 0));
    #1;
    reset_n = 1'b1;
    cyc(3);
    key_n = 3'b010;
    cyc(5);
    check("rst_pre_start", {count, running, count_up, tick}, pk(24'h0, 0, 1, 0));
    cyc(1);
    check("rst_start", {count, running, count_up, tick}, pk(24'h0, 1, 1, 0));
    cyc(3);
    check("rst_held_t1", {count, running, count_up, tick}, pk(24'h1, 1, 1, 1));
    cyc(3);
    check("rst_held_t2", {count, running, count_up, tick}, pk(24'h2, 1, 1, 1));
    key_n = 3'b111;
    cyc(6);
    check("rst_released", {count, running, count_up, tick}, pk(24'h4, 1, 1, 1));
    key_n = 3'b011;
    cyc(3);
    check("repress_t", {count, running, count_up, tick}, pk(24'h5, 1, 1, 1));
    cyc(2);
    check("repress_wait", {count, running, count_up, tick}, pk(24'h5, 1, 1, 0));
    cyc(1);
    check("repress_clear", {count, running, count_up, tick}, pk(24'h0, 1, 1, 0));
    key_n = 3'b111;
    cyc(3);
    check("after_clear", {count, running, count_up, tick}, pk(24'h1, 1, 1, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
